// File: rtl/add_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM state encoding
// and the single-bit full-adder cell that the chunk adder ripples.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One full-adder cell; returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/ripple_chunk_adder.sv
// CHUNK-bit ripple-carry adder built from the package full-adder cell.
// Besides the carry out it exposes the carry into the MSB so the caller can
// derive signed overflow on the final chunk.
module ripple_chunk_adder
    import add_sub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0]   carry_s;
    logic [CHUNK-1:0] s_s;

    // Ripple the carry through CHUNK full-adder cells, LSB first.
    always_comb begin
        carry_s    = '0;
        s_s        = '0;
        carry_s[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            {carry_s[i+1], s_s[i]} = full_add(x[i], y[i], carry_s[i]);
        end
    end

    assign s    = s_s;
    assign cout = carry_s[CHUNK];
    assign cmsb = carry_s[CHUNK-1];

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per clock.
// Subtraction is A + ~B + 1, so B is inverted and the carry seeded with 1 at
// accept time. Results are held in registers until the consumer takes them.
module chunked_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
        $error("chunked_add_sub: WIDTH must be an integer multiple of CHUNK");
    end

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [KW-1:0]    k_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [31:0]      base_s;
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] s_chunk_s;
    logic             co_s;
    logic             cmsb_s;

    assign base_s    = 32'(k_r) * 32'(CHUNK);
    assign a_chunk_s = CHUNK'(a_r >> base_s);
    assign b_chunk_s = CHUNK'(b_r >> base_s);

    ripple_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x    (a_chunk_s),
        .y    (b_chunk_s),
        .cin  (carry_r),
        .s    (s_chunk_s),
        .cout (co_s),
        .cmsb (cmsb_s)
    );

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            carry_r     <= 1'b0;
            k_r         <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= b ^ {WIDTH{sub}};
                        carry_r    <= sub;
                        k_r        <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= CALC;
                    end
                end
                CALC: begin
                    sum_r   <= (sum_r & ~(CHUNK_MASK << base_s))
                             | (WIDTH'(s_chunk_s) << base_s);
                    carry_r <= co_s;
                    if (k_r == KW'(NCHUNK - 1)) begin
                        cout_r      <= co_s;
                        ovf_r       <= cmsb_s ^ co_s;
                        k_r         <= '0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    k_r         <= '0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Self-checking bench for chunked_add_sub: directed corner cases on the
// default 16/4 configuration, then random traffic on four configurations
// checked against an arithmetic reference model.
module tb_chunked_add_sub;

    localparam int OPS = 1000;
    localparam int CYCLE_CAP = 60000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv [4];
    logic        orr[4];
    logic        ir [4];
    logic        ov [4];
    logic        co [4];
    logic        vf [4];
    logic        sb [4];
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [15:0] s0;
    logic [15:0] s1;
    logic [7:0]  s2;
    logic [31:0] s3;

    int errors = 0;
    int checks = 0;

    int wid[4] = '{16, 16, 8, 32};
    int nch[4] = '{4, 1, 8, 4};

    chunked_add_sub #(.WIDTH(16), .CHUNK(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][15:0]), .b(bv[0][15:0]), .sub(sb[0]), .out_valid(ov[0]),
        .out_ready(orr[0]), .sum(s0), .cout(co[0]), .ovf(vf[0]));
    chunked_add_sub #(.WIDTH(16), .CHUNK(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1][15:0]), .b(bv[1][15:0]), .sub(sb[1]), .out_valid(ov[1]),
        .out_ready(orr[1]), .sum(s1), .cout(co[1]), .ovf(vf[1]));
    chunked_add_sub #(.WIDTH(8), .CHUNK(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av[2][7:0]), .b(bv[2][7:0]), .sub(sb[2]), .out_valid(ov[2]),
        .out_ready(orr[2]), .sum(s2), .cout(co[2]), .ovf(vf[2]));
    chunked_add_sub #(.WIDTH(32), .CHUNK(8)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(av[3]), .b(bv[3]), .sub(sb[3]), .out_valid(ov[3]),
        .out_ready(orr[3]), .sum(s3), .cout(co[3]), .ovf(vf[3]));

    function automatic logic [31:0] sumof(input int i);
        case (i)
            0:       return {16'd0, s0};
            1:       return {16'd0, s1};
            2:       return {24'd0, s2};
            default: return s3;
        endcase
    endfunction

    // Reference: plain integer arithmetic; returns {cout, ovf, sum}.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic s);
        longint m, ua, ub, sa, sbb, r, sr;
        logic c, v;
        m   = longint'(1) << w;
        ua  = longint'(a) & (m - 1);
        ub  = longint'(b) & (m - 1);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sbb = (ub >= m / 2) ? ub - m : ub;
        r   = s ? ua - ub : ua + ub;
        c   = s ? (ua >= ub) : (r >= m);
        sr  = s ? sa - sbb : sa + sbb;
        v   = (sr >= m / 2) || (sr < -(m / 2));
        return {c, v, 32'(r & (m - 1))};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Directed operation on the 16/4 instance, with operand noise during CALC.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] es, input logic ec,
                          input logic eo, input int hold);
        int lat;
        logic [17:0] held;
        @(negedge clk);
        check({tag, "_inready"}, 64'(ir[0]), 64'd1);
        av[0] = 32'(a); bv[0] = 32'(b); sb[0] = s; iv[0] = 1'b1;
        orr[0] = (hold == 0);
        @(negedge clk);
        lat = 1;
        while (!ov[0] && lat < 40) begin
            av[0] = $urandom; bv[0] = $urandom; sb[0] = 1'($urandom); iv[0] = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        iv[0] = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'd5);
        check({tag, "_result"}, 64'({s0, co[0], vf[0]}), 64'({es, ec, eo}));
        held = {s0, co[0], vf[0]};
        for (int h = 0; h < hold; h++) begin
            iv[0] = 1'b1; av[0] = $urandom; bv[0] = $urandom; sb[0] = 1'($urandom);
            @(negedge clk);
            check({tag, "_hold"}, 64'({ir[0], ov[0], s0, co[0], vf[0]}), 64'({2'b01, held}));
        end
        iv[0] = 1'b0; orr[0] = 1'b1;
        @(negedge clk);
        check({tag, "_back_idle"}, 64'({ir[0], ov[0]}), 64'(2'b10));
    endtask

    initial begin
        int done_cnt[4];
        bit busy[4];
        bit seen[4];
        int lat[4];
        logic [33:0] expv[4];
        int cyc;
        bit any_valid;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; orr[i] = 1'b1; sb[i] = 1'b0; av[i] = 32'd0; bv[i] = 32'd0;
            done_cnt[i] = 0; busy[i] = 1'b0; seen[i] = 1'b0; lat[i] = 0; expv[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("reset_state", 64'({ir[i], ov[i], co[i], vf[i], sumof(i)}), 64'({4'b1000, 32'd0}));
        end
        rst_n = 1'b1;

        run_op("add_5555", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 3);

        // Abort during the second CALC cycle.
        @(negedge clk);
        av[0] = 32'h0000_7FFF; bv[0] = 32'h0000_0001; sb[0] = 1'b0; iv[0] = 1'b1; orr[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_reset", 64'({ir[0], ov[0], co[0], vf[0], s0}), 64'({4'b1000, 16'd0}));
        any_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            any_valid = any_valid | ov[0];
        end
        check("abort_no_valid", 64'(any_valid), 64'd0);
        run_op("after_abort", 16'h0F0F, 16'h0101, 1'b1, 16'h0E0E, 1'b1, 1'b0, 0);

        // Random traffic on all four configurations concurrently.
        cyc = 0;
        while ((done_cnt[0] < OPS || done_cnt[1] < OPS || done_cnt[2] < OPS ||
                done_cnt[3] < OPS) && cyc < CYCLE_CAP) begin
            for (int i = 0; i < 4; i++) begin
                if (busy[i] && !seen[i]) lat[i]++;
                if (ov[i] && busy[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    check("rnd_latency", 64'(lat[i]), 64'(nch[i] + 1));
                end
                orr[i] = ($urandom_range(3) != 0);
                if (ov[i] && orr[i]) begin
                    check("rnd_result", 64'({co[i], vf[i], sumof(i)}), 64'(expv[i]));
                    busy[i] = 1'b0;
                    done_cnt[i]++;
                end
                iv[i] = 1'b0;
                av[i] = $urandom; bv[i] = $urandom; sb[i] = 1'($urandom);
                if (!busy[i] && ir[i] && done_cnt[i] < OPS && $urandom_range(1) == 1) begin
                    iv[i]   = 1'b1;
                    busy[i] = 1'b1;
                    seen[i] = 1'b0;
                    lat[i]  = 0;
                    expv[i] = ref_op(wid[i], av[i], bv[i], sb[i]);
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("rnd_cycle_budget", 64'(cyc < CYCLE_CAP), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chunked_add_sub.md
CHUNKED_ADD_SUB -- requirements
Module: chunked_add_sub

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 16, operand and result width in bits.
REQ-002 The block SHALL expose parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand set A/B/sub is valid.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  WIDTH  operand A (two's complement or unsigned).
REQ-008 b  input  WIDTH  operand B.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sum  output  WIDTH  result A+B or A-B, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-014 ovf  output  1  signed two's-complement overflow.

Function
REQ-015 FSM states SHALL be IDLE, CALC, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; accept occurs on a cycle with in_valid=1 and in_ready=1.
REQ-017 On accept the block SHALL register A, B XOR {WIDTH{sub}}, carry-in = sub, clear chunk index, and move to CALC.
REQ-018 In CALC, each cycle SHALL add chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) with the registered carry, write the chunk of sum, update carry, increment k.
REQ-019 After the last chunk (k = WIDTH/CHUNK-1) the FSM SHALL go to DONE; CALC lasts exactly WIDTH/CHUNK cycles.
REQ-020 out_valid SHALL be 1 exactly in DONE; first out_valid cycle SHALL be WIDTH/CHUNK+1 cycles after the accept cycle (5 for defaults).
REQ-021 cout SHALL equal the carry out of the final chunk; ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-022 sum, cout, ovf SHALL hold stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-023 DONE with out_ready=1 SHALL return to IDLE; in_ready rises the following cycle (no same-cycle accept in DONE).
REQ-024 in_valid, a, b, sub SHALL be ignored outside IDLE; operand changes during CALC SHALL not affect the result.
REQ-025 CHUNK = WIDTH SHALL give one CALC cycle; CHUNK = 1 SHALL give WIDTH CALC cycles.

Reset
REQ-026 With rst_n=0 at a rising edge the FSM SHALL enter IDLE; in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry and chunk index 0.
REQ-027 Reset asserted in CALC or DONE SHALL abort the operation; no out_valid SHALL be produced for it.

Structure
REQ-028 State encodings (IDLE/CALC/DONE) SHALL live in shared package add_sub_pkg; WIDTH/CHUNK stay module parameters.
REQ-029 The per-cycle CHUNK-bit adder SHALL be one sub-module, ripple_chunk_adder (CHUNK-bit ripple of the existing full-adder cell, carry in, carry out, carry into MSB).

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-030 add 0x1234+0x4321 -> sum 0x5555, cout 0, ovf 0, out_valid exactly 5 cycles after accept.
REQ-031 add 0xFFFF+0x0001 -> sum 0x0000, cout 1, ovf 0; add 0x7FFF+0x0001 -> sum 0x8000, cout 0, ovf 1.
REQ-032 sub 0x0005-0x0007 -> sum 0xFFFE, cout 0, ovf 0; sub 0x8000-0x0001 -> sum 0x7FFF, cout 1, ovf 1.
REQ-033 out_ready held 0 for 3 cycles in DONE -> outputs stable, in_ready 0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-034 rst_n=0 during 2nd CALC cycle -> next cycle IDLE, all outputs at reset values, no out_valid; new operation then completes correctly.
REQ-035 Random 1000 operations at (WIDTH,CHUNK) = (16,4), (16,16), (8,1), (32,8) against a reference model with random in_valid/out_ready gaps -> all fields match.
